// File: rtl/rx78_video_pkg.sv
// Shared constants and types for the RX-78 video colour path.
// Timing defaults, plane storage type, fetch states and the colour priority rule.
package rx78_video_pkg;

    localparam int H_START_DEF  = 24;
    localparam int V_START_DEF  = 16;
    localparam int H_ACTIVE_DEF = 192;
    localparam int V_ACTIVE_DEF = 184;
    localparam int BPL_DEF      = H_ACTIVE_DEF / 8;
    localparam int NUM_PLANES   = 6;

    typedef logic [NUM_PLANES-1:0][7:0] plane_bytes_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH
    } fetch_state_t;

    // Colour indices are {B,G,R}
    localparam logic [2:0] COL_BLACK   = 3'b000;
    localparam logic [2:0] COL_RED     = 3'b001;
    localparam logic [2:0] COL_GREEN   = 3'b010;
    localparam logic [2:0] COL_YELLOW  = 3'b011;
    localparam logic [2:0] COL_BLUE    = 3'b100;
    localparam logic [2:0] COL_MAGENTA = 3'b101;
    localparam logic [2:0] COL_CYAN    = 3'b110;
    localparam logic [2:0] COL_WHITE   = 3'b111;

    // Foreground planes 1-3 win over background planes 4-6, which win over bgc.
    function automatic logic [2:0] pick_colour(input logic [5:0] a, input logic [2:0] bg_colour);
        if (a[2:0] != COL_BLACK)
            return a[2:0];
        else if (a[5:3] != COL_BLACK)
            return a[5:3];
        else
            return bg_colour;
    endfunction

endpackage

// File: rtl/rx78_plane_shifter.sv
// One bitplane serialiser: parallel load, shift right, LSB is the current pixel.
module rx78_plane_shifter
    import rx78_video_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    output logic       pix
);

    logic [7:0] q;
    logic [7:0] q_next;

    always_comb begin
        q_next = q;
        if (load)
            q_next = din;
        else if (shift)
            q_next = {1'b0, q[7:1]};
    end

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else
            q <= q_next;
    end

    // Post-update bit, so the compose register captures this pixel on the same ce_pix
    assign pix = q_next[0];

endmodule

// File: rtl/rx78_vram_scanout.sv
// VRAM read-side scanout: fetches six bitplanes per 8-pixel column, serialises them,
// applies plane mask and fg/bg priority, and drives registered RGB888.
module rx78_vram_scanout
    import rx78_video_pkg::*;
#(
    parameter int H_START  = H_START_DEF,
    parameter int V_START  = V_START_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BPL      = BPL_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic [8:0]  h,
    input  logic [8:0]  v,
    output logic [12:0] vram_addr,
    input  logic [7:0]  v1,
    input  logic [7:0]  v2,
    input  logic [7:0]  v3,
    input  logic [7:0]  v4,
    input  logic [7:0]  v5,
    input  logic [7:0]  v6,
    input  logic [7:0]  mask,
    input  logic [7:0]  bgc,
    output logic        active,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue
);

    localparam logic [8:0]  H_FETCH0  = 9'(H_START - 8);
    localparam logic [8:0]  H_FIRST   = 9'(H_START);
    localparam logic [8:0]  H_END     = 9'(H_START + H_ACTIVE);
    localparam logic [8:0]  H_SPAN    = 9'(H_ACTIVE);
    localparam logic [8:0]  V_FIRST   = 9'(V_START);
    localparam logic [8:0]  V_END     = 9'(V_START + V_ACTIVE);
    localparam logic [12:0] LINE_STEP = 13'(BPL);

    fetch_state_t state;
    plane_bytes_t holding;
    logic [12:0]  line_base;
    logic [12:0]  base_now;
    logic         frame_ok;
    logic         line_act;
    logic         pix_act;
    logic         fetch_hit;
    logic         load_col;
    logic [8:0]   h_rel_fetch;
    logic [8:0]   h_rel_pix;
    logic [5:0]   pix_bits;
    logic [2:0]   col3;
    logic         unused_bits;

    assign unused_bits = ^{mask[7:6], bgc[7:3]};

    // Window decode; base_now folds in the h==0 line step so a fetch at h==0 sees the new line.
    always_comb begin
        line_act    = (v >= V_FIRST) && (v < V_END);
        h_rel_fetch = h - H_FETCH0;
        h_rel_pix   = h - H_FIRST;
        fetch_hit   = line_act && (h >= H_FETCH0) && (h_rel_fetch < H_SPAN)
                      && (h_rel_fetch[2:0] == 3'd0);
        pix_act     = line_act && (h >= H_FIRST) && (h < H_END);
        load_col    = pix_act && (h_rel_pix[2:0] == 3'd0);
        base_now    = line_base;
        if (h == 9'd0) begin
            if (v == V_FIRST)
                base_now = '0;
            else if (line_act)
                base_now = line_base + LINE_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_base <= '0;
            frame_ok  <= 1'b0;
        end else if (ce_pix) begin
            line_base <= base_now;
            if ((v == V_FIRST) && (h == 9'd0))
                frame_ok <= 1'b1;
        end
    end

    // Column fetch: address goes out, plane bytes are valid one clock later and land in holding.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            vram_addr <= '0;
            holding   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ce_pix && fetch_hit) begin
                        vram_addr <= base_now + {7'd0, h_rel_fetch[8:3]};
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_LATCH;
                ST_LATCH: begin
                    holding <= {v6, v5, v4, v3, v2, v1};
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_PLANES; i++) begin : g_plane
        rx78_plane_shifter u_shift (
            .clk   (clk),
            .reset (reset),
            .load  (ce_pix && load_col),
            .shift (ce_pix && pix_act && !load_col),
            .din   (holding[i]),
            .pix   (pix_bits[i])
        );
    end

    always_comb begin
        col3 = pick_colour(pix_bits & mask[5:0], bgc[2:0]);
    end

    // Output stays black until the first V_START after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else if (ce_pix) begin
            if (frame_ok && pix_act) begin
                active <= 1'b1;
                red    <= {8{col3[0]}};
                green  <= {8{col3[1]}};
                blue   <= {8{col3[2]}};
            end else begin
                active <= 1'b0;
                red    <= '0;
                green  <= '0;
                blue   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rx78_vram_scanout.sv
// Directed bench for rx78_vram_scanout; the bench acts as timing generator and VRAM.
module tb_rx78_vram_scanout;

    localparam int HS  = 24;
    localparam int VS  = 16;
    localparam int HA  = 192;
    localparam int VA  = 184;
    localparam int BPL = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_pix;
    logic [8:0]  h;
    logic [8:0]  v;
    logic [12:0] vram_addr;
    logic [7:0]  v1, v2, v3, v4, v5, v6;
    logic [7:0]  mask;
    logic [7:0]  bgc;
    logic        active;
    logic [7:0]  red, green, blue;

    logic [7:0]  mem [0:5][0:8191];
    logic        cap_act  [0:255][0:255];
    logic [23:0] cap_rgb  [0:255][0:255];
    logic [12:0] cap_addr [0:255][0:255];
    logic [12:0] addr_start [0:255];
    bit          full_line [0:255];

    int vectors = 0;
    int errors  = 0;

    assign v1 = mem[0][vram_addr];
    assign v2 = mem[1][vram_addr];
    assign v3 = mem[2][vram_addr];
    assign v4 = mem[3][vram_addr];
    assign v5 = mem[4][vram_addr];
    assign v6 = mem[5][vram_addr];

    always #5 clk = ~clk;

    rx78_vram_scanout dut (
        .clk       (clk),
        .reset     (reset),
        .ce_pix    (ce_pix),
        .h         (h),
        .v         (v),
        .vram_addr (vram_addr),
        .v1        (v1),
        .v2        (v2),
        .v3        (v3),
        .v4        (v4),
        .v5        (v5),
        .v6        (v6),
        .mask      (mask),
        .bgc       (bgc),
        .active    (active),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    // One ce_pix every 3 clocks; outputs are sampled on the falling edge after it.
    task automatic pix_step(input int hh, input int vv);
        @(negedge clk);
        @(negedge clk);
        ce_pix = 1'b1;
        h      = 9'(hh);
        v      = 9'(vv);
        @(negedge clk);
        ce_pix = 1'b0;
        cap_act[vv][hh]  = active;
        cap_rgb[vv][hh]  = {red, green, blue};
        cap_addr[vv][hh] = vram_addr;
    endtask

    task automatic run_line(input int vv, input bit full);
        addr_start[vv] = vram_addr;
        pix_step(0, vv);
        if (full)
            for (int hh = HS - 8; hh <= HS + HA + 1; hh++)
                pix_step(hh, vv);
    endtask

    task automatic run_frame();
        for (int vv = VS - 1; vv <= VS + VA; vv++)
            run_line(vv, full_line[vv]);
    endtask

    task automatic clear_lines();
        for (int i = 0; i < 256; i++) full_line[i] = 1'b0;
    endtask

    task automatic fill_mem(input bit pattern, input int seed);
        for (int i = 0; i < 6; i++)
            for (int a = 0; a < 8192; a++)
                mem[i][a] = pattern ? 8'((a * 13 + i * 51 + seed) ^ (a >> 4)) : 8'(seed);
    endtask

    // Reference pixel {active, R, G, B} computed from the bench VRAM image.
    function automatic logic [24:0] exp_pixel(input int hh, input int vv, input bit ok);
        int x, y, addr;
        logic [5:0] a;
        logic [2:0] c;
        if (!ok || vv < VS || vv >= VS + VA || hh < HS || hh >= HS + HA)
            return '0;
        x = hh - HS;
        y = vv - VS;
        addr = y * BPL + x / 8;
        for (int i = 0; i < 6; i++) a[i] = mem[i][addr][x % 8];
        a = a & mask[5:0];
        if (a[2:0] != 3'b000)      c = a[2:0];
        else if (a[5:3] != 3'b000) c = a[5:3];
        else                       c = bgc[2:0];
        return {1'b1, {8{c[0]}}, {8{c[1]}}, {8{c[2]}}};
    endfunction

    task automatic test_reset();
        reset = 1'b1; ce_pix = 1'b0; h = '0; v = '0; mask = 8'h3F; bgc = 8'h00;
        fill_mem(1'b0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (vram_addr !== 13'd0) begin
            errors++; $display("[TB] FAIL reset_addr: got %0d, expected 0", vram_addr);
        end
        vectors++;
        if (active !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_active: got %b, expected 0", active);
        end
        vectors++;
        if ({red, green, blue} !== 24'h0) begin
            errors++; $display("[TB] FAIL reset_rgb: got %h, expected 000000", {red, green, blue});
        end
        // An active line before any V_START must stay black.
        run_line(20, 1'b1);
        for (int hh = 0; hh <= HS + HA + 1; hh++) begin
            if (hh == 0 || hh >= HS - 8) begin
                vectors++;
                if ({cap_act[20][hh], cap_rgb[20][hh]} !== 25'd0) begin
                    errors++;
                    $display("[TB] FAIL preframe_black h=%0d: got %h, expected 0", hh,
                             {cap_act[20][hh], cap_rgb[20][hh]});
                end
            end
        end
    endtask

    task automatic test_background();
        int lines [6];
        int cnt, exp_cnt;
        logic [24:0] exp;
        lines = '{15, 16, 17, 100, 199, 200};
        fill_mem(1'b0, 0);
        mask = 8'h3F; bgc = 8'h04;
        clear_lines();
        foreach (lines[k]) full_line[lines[k]] = 1'b1;
        run_frame();
        foreach (lines[k]) begin
            cnt = 0;
            exp_cnt = (lines[k] >= VS && lines[k] < VS + VA) ? HA : 0;
            for (int hh = 0; hh <= HS + HA + 1; hh++) begin
                if (hh == 0 || hh >= HS - 8) begin
                    exp = (exp_cnt != 0 && hh >= HS && hh < HS + HA) ? {1'b1, 24'h0000FF} : 25'd0;
                    if (cap_act[lines[k]][hh] === 1'b1) cnt++;
                    vectors++;
                    if ({cap_act[lines[k]][hh], cap_rgb[lines[k]][hh]} !== exp) begin
                        errors++;
                        $display("[TB] FAIL bg_pixel v=%0d h=%0d: got %h, expected %h", lines[k], hh,
                                 {cap_act[lines[k]][hh], cap_rgb[lines[k]][hh]}, exp);
                    end
                end
            end
            vectors++;
            if (cnt !== exp_cnt) begin
                errors++;
                $display("[TB] FAIL bg_active_count v=%0d: got %0d, expected %0d", lines[k], cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_single_pixel();
        fill_mem(1'b0, 0);
        mem[0][0] = 8'h01;
        mask = 8'h3F; bgc = 8'h00;
        clear_lines();
        full_line[16] = 1'b1; full_line[17] = 1'b1;
        run_frame();
        vectors++;
        if ({cap_act[16][24], cap_rgb[16][24]} !== {1'b1, 24'hFF0000}) begin
            errors++; $display("[TB] FAIL px_0_0: got %h, expected 1ff0000", {cap_act[16][24], cap_rgb[16][24]});
        end
        vectors++;
        if ({cap_act[16][25], cap_rgb[16][25]} !== {1'b1, 24'h000000}) begin
            errors++; $display("[TB] FAIL px_1_0: got %h, expected 1000000", {cap_act[16][25], cap_rgb[16][25]});
        end
        vectors++;
        if ({cap_act[17][24], cap_rgb[17][24]} !== {1'b1, 24'h000000}) begin
            errors++; $display("[TB] FAIL px_0_1: got %h, expected 1000000", {cap_act[17][24], cap_rgb[17][24]});
        end
        for (int vv = 16; vv <= 17; vv++)
            for (int hh = HS - 8; hh <= HS + HA + 1; hh++) begin
                vectors++;
                if ({cap_act[vv][hh], cap_rgb[vv][hh]} !== exp_pixel(hh, vv, 1'b1)) begin
                    errors++;
                    $display("[TB] FAIL single_line v=%0d h=%0d: got %h, expected %h", vv, hh,
                             {cap_act[vv][hh], cap_rgb[vv][hh]}, exp_pixel(hh, vv, 1'b1));
                end
            end
    endtask

    task automatic test_priority();
        fill_mem(1'b0, 0);
        mem[0][0] = 8'hFF;
        mem[5][0] = 8'hFF;
        mask = 8'h3F; bgc = 8'h00;
        clear_lines();
        full_line[16] = 1'b1;
        run_frame();
        for (int hh = HS; hh <= HS + 8; hh++) begin
            vectors++;
            if ({cap_act[16][hh], cap_rgb[16][hh]} !== ((hh < HS + 8) ? {1'b1, 24'hFF0000} : {1'b1, 24'h0})) begin
                errors++;
                $display("[TB] FAIL prio_fg h=%0d: got %h, expected %s", hh,
                         {cap_act[16][hh], cap_rgb[16][hh]}, (hh < HS + 8) ? "1ff0000" : "1000000");
            end
        end
        mask = 8'h3E;
        run_frame();
        for (int hh = HS; hh < HS + 8; hh++) begin
            vectors++;
            if ({cap_act[16][hh], cap_rgb[16][hh]} !== {1'b1, 24'h0000FF}) begin
                errors++;
                $display("[TB] FAIL prio_bg h=%0d: got %h, expected 10000ff", hh, {cap_act[16][hh], cap_rgb[16][hh]});
            end
        end
    endtask

    task automatic test_mask_zero();
        int lines [3];
        logic [24:0] exp;
        lines = '{16, 66, 199};
        fill_mem(1'b0, 8'hFF);
        mask = 8'h00; bgc = 8'h02;
        clear_lines();
        foreach (lines[k]) full_line[lines[k]] = 1'b1;
        run_frame();
        foreach (lines[k])
            for (int hh = HS - 8; hh <= HS + HA + 1; hh++) begin
                exp = (hh >= HS && hh < HS + HA) ? {1'b1, 24'h00FF00} : 25'd0;
                vectors++;
                if ({cap_act[lines[k]][hh], cap_rgb[lines[k]][hh]} !== exp) begin
                    errors++;
                    $display("[TB] FAIL mask0 v=%0d h=%0d: got %h, expected %h", lines[k], hh,
                             {cap_act[lines[k]][hh], cap_rgb[lines[k]][hh]}, exp);
                end
            end
    endtask

    task automatic test_address();
        int lines [6];
        int vv;
        lines = '{15, 16, 17, 120, 199, 200};
        fill_mem(1'b1, 7);
        mask = 8'h3F; bgc = 8'h03;
        clear_lines();
        foreach (lines[k]) full_line[lines[k]] = 1'b1;
        run_frame();
        vectors++;
        if (cap_addr[16][16] !== 13'd0) begin
            errors++; $display("[TB] FAIL addr_line0_col0: got %0d, expected 0", cap_addr[16][16]);
        end
        vectors++;
        if (cap_addr[17][16] !== 13'd24) begin
            errors++; $display("[TB] FAIL addr_line1_col0: got %0d, expected 24", cap_addr[17][16]);
        end
        vectors++;
        if (cap_addr[199][200] !== 13'd4415) begin
            errors++; $display("[TB] FAIL addr_last: got %0d, expected 4415", cap_addr[199][200]);
        end
        foreach (lines[k]) begin
            vv = lines[k];
            if (vv >= VS && vv < VS + VA) begin
                for (int c = 0; c < BPL; c++) begin
                    vectors++;
                    if (cap_addr[vv][HS - 8 + 8 * c] !== 13'((vv - VS) * BPL + c)) begin
                        errors++;
                        $display("[TB] FAIL addr_col v=%0d c=%0d: got %0d, expected %0d", vv, c,
                                 cap_addr[vv][HS - 8 + 8 * c], (vv - VS) * BPL + c);
                    end
                end
            end else begin
                for (int hh = HS - 8; hh <= HS + HA + 1; hh++) begin
                    vectors++;
                    if (cap_addr[vv][hh] !== addr_start[vv]) begin
                        errors++;
                        $display("[TB] FAIL addr_idle v=%0d h=%0d: got %0d, expected %0d", vv, hh,
                                 cap_addr[vv][hh], addr_start[vv]);
                    end
                end
            end
            for (int hh = HS - 8; hh <= HS + HA + 1; hh++) begin
                vectors++;
                if ({cap_act[vv][hh], cap_rgb[vv][hh]} !== exp_pixel(hh, vv, 1'b1)) begin
                    errors++;
                    $display("[TB] FAIL pattern v=%0d h=%0d: got %h, expected %h", vv, hh,
                             {cap_act[vv][hh], cap_rgb[vv][hh]}, exp_pixel(hh, vv, 1'b1));
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int black [4];
        int ref_lines [4];
        black = '{106, 107, 150, 199};
        ref_lines = '{16, 17, 106, 199};
        fill_mem(1'b1, 91);
        mask = 8'h3F; bgc = 8'h06;
        clear_lines();
        for (int vv = VS - 1; vv < 106; vv++) run_line(vv, 1'b0);
        pix_step(0, 106);
        for (int hh = HS - 8; hh <= 96; hh++) pix_step(hh, 106);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({active, red, green, blue, vram_addr} !== 38'd0) begin
            errors++;
            $display("[TB] FAIL midreset_state: got act=%b rgb=%h addr=%0d, expected all 0",
                     active, {red, green, blue}, vram_addr);
        end
        for (int hh = 97; hh <= HS + HA + 1; hh++) pix_step(hh, 106);
        full_line[107] = 1'b1; full_line[150] = 1'b1; full_line[199] = 1'b1;
        for (int vv = 107; vv <= VS + VA; vv++) run_line(vv, full_line[vv]);
        foreach (black[k])
            for (int hh = (black[k] == 106) ? 97 : HS - 8; hh <= HS + HA + 1; hh++) begin
                vectors++;
                if ({cap_act[black[k]][hh], cap_rgb[black[k]][hh]} !== 25'd0) begin
                    errors++;
                    $display("[TB] FAIL midreset_black v=%0d h=%0d: got %h, expected 0", black[k], hh,
                             {cap_act[black[k]][hh], cap_rgb[black[k]][hh]});
                end
            end
        clear_lines();
        foreach (ref_lines[k]) full_line[ref_lines[k]] = 1'b1;
        run_frame();
        foreach (ref_lines[k])
            for (int hh = HS - 8; hh <= HS + HA + 1; hh++) begin
                vectors++;
                if ({cap_act[ref_lines[k]][hh], cap_rgb[ref_lines[k]][hh]} !== exp_pixel(hh, ref_lines[k], 1'b1)) begin
                    errors++;
                    $display("[TB] FAIL midreset_next v=%0d h=%0d: got %h, expected %h", ref_lines[k], hh,
                             {cap_act[ref_lines[k]][hh], cap_rgb[ref_lines[k]][hh]},
                             exp_pixel(hh, ref_lines[k], 1'b1));
                end
            end
    endtask

    initial begin
        test_reset();
        test_background();
        test_single_pixel();
        test_priority();
        test_mask_zero();
        test_address();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
